// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one sdram_controller between two requesters (e.g. port 0 =
//   instruction fetch, port 1 = data access). Each port raises a level
//   request (rd_en/wr_en) and holds its operands until a one-cycle ack.
//   The winning request is latched into the ctrl_* registers, the
//   controller's rd_enable/wr_enable/busy handshake is run, and read data
//   is returned to the owning port.
//
//   Build option: SDRAM_ARBITER_ROUND_ROBIN_EN
//     undefined : fixed priority, port 0 wins ties.
//     defined   : ties go to the port that did not win the previous grant.
//
// Ports
//   clock, reset            system clock, async active-low reset
//   pN_rd_en, pN_wr_en      port N level requests (both high = write)
//   pN_addr, pN_size        port N address / size (00 B, 01 H, 10 W, 11 D)
//   pN_wr_data              port N write data
//   pN_rd_data              port N last read result (held until next read)
//   pN_ack                  port N one-cycle completion pulse
//   ctrl_*                  controller handshake, address, size, data
//   grant                   owner of the current / last transaction
//   arb_busy                high whenever the FSM is not IDLE
//
// state  | meaning
// IDLE   | waiting for a request; grants and latches the winner
// ISSUE  | enable held toward controller until it reports busy
// WAIT   | controller busy; read data captured when busy falls
// DONE   | ack pulse to the granted port
module sdram_arbiter #(
  parameter int addr_size = 26,
  parameter int data_size = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 p0_rd_en,
  input  logic                 p0_wr_en,
  input  logic [addr_size-1:0] p0_addr,
  input  logic [1:0]           p0_size,
  input  logic [data_size-1:0] p0_wr_data,
  output logic [data_size-1:0] p0_rd_data,
  output logic                 p0_ack,
  input  logic                 p1_rd_en,
  input  logic                 p1_wr_en,
  input  logic [addr_size-1:0] p1_addr,
  input  logic [1:0]           p1_size,
  input  logic [data_size-1:0] p1_wr_data,
  output logic [data_size-1:0] p1_rd_data,
  output logic                 p1_ack,
  output logic                 ctrl_rd_enable,
  output logic                 ctrl_wr_enable,
  output logic [addr_size-1:0] ctrl_address,
  output logic [1:0]           ctrl_rd_wr_size,
  output logic [data_size-1:0] ctrl_write_data,
  input  logic                 ctrl_busy,
  input  logic [data_size-1:0] ctrl_read_data,
  output logic                 grant,
  output logic                 arb_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e               state_q;
  logic                 op_wr_q;
  logic                 grant_q;
  logic                 rd_en_q;
  logic                 wr_en_q;
  logic [addr_size-1:0] addr_q;
  logic [1:0]           size_q;
  logic [data_size-1:0] wdata_q;
  logic [data_size-1:0] p0_rd_q;
  logic [data_size-1:0] p1_rd_q;

  logic req0, req1, any_req;
  logic win_d;
  logic sel_wr_d;

  assign req0    = p0_rd_en | p0_wr_en;
  assign req1    = p1_rd_en | p1_wr_en;
  assign any_req = req0 | req1;

`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
  logic last_win_q;

  // Reset value 1 makes port 0 the first tie winner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_win_q <= 1'b1;
    end else if (state_q == ST_IDLE && any_req) begin
      last_win_q <= win_d;
    end
  end

  assign win_d = (req0 && req1) ? ~last_win_q : ~req0;
`else
  // Only consulted when some request is present: port 1 wins only alone.
  assign win_d = ~req0;
`endif

  // A simultaneous rd_en and wr_en is treated as a write.
  assign sel_wr_d = win_d ? p1_wr_en : p0_wr_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_wr_q <= 1'b0;
      grant_q <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      p0_rd_q <= '0;
      p1_rd_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_q <= win_d;
            op_wr_q <= sel_wr_d;
            rd_en_q <= ~sel_wr_d;
            wr_en_q <= sel_wr_d;
            addr_q  <= win_d ? p1_addr    : p0_addr;
            size_q  <= win_d ? p1_size    : p0_size;
            wdata_q <= win_d ? p1_wr_data : p0_wr_data;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ctrl_busy) begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!ctrl_busy) begin
            if (!op_wr_q) begin
              if (grant_q) p1_rd_q <= ctrl_read_data;
              else         p0_rd_q <= ctrl_read_data;
            end
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ctrl_rd_enable  = rd_en_q;
  assign ctrl_wr_enable  = wr_en_q;
  assign ctrl_address    = addr_q;
  assign ctrl_rd_wr_size = size_q;
  assign ctrl_write_data = wdata_q;
  assign p0_rd_data      = p0_rd_q;
  assign p1_rd_data      = p1_rd_q;
  assign grant           = grant_q;
  assign arb_busy        = (state_q != ST_IDLE);
  assign p0_ack          = (state_q == ST_DONE) && !grant_q;
  assign p1_ack          = (state_q == ST_DONE) &&  grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small behavioural controller:
// once an enable is seen the controller waits `holdoff` extra cycles,
// then holds busy for `busy_len` cycles.
module tb_sdram_arbiter;
  localparam int AW = 26;
  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          p0_rd_en, p0_wr_en, p1_rd_en, p1_wr_en;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [1:0]    p0_size, p1_size;
  logic [DW-1:0] p0_wr_data, p1_wr_data, p0_rd_data, p1_rd_data;
  logic          p0_ack, p1_ack;
  logic          ctrl_rd_enable, ctrl_wr_enable, ctrl_busy;
  logic [AW-1:0] ctrl_address;
  logic [1:0]    ctrl_rd_wr_size;
  logic [DW-1:0] ctrl_write_data, ctrl_read_data;
  logic          grant, arb_busy;

  int n_vec  = 0;
  int n_miss = 0;
  int busy_len = 5;
  int holdoff  = 0;
  int busy_cnt, pre_cnt;
  int rd_cyc = 0, wr_cyc = 0, a0_cyc = 0, a1_cyc = 0;

  sdram_arbiter #(.addr_size(AW), .data_size(DW)) dut (
    .clock(clock), .reset(reset),
    .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_addr(p0_addr),
    .p0_size(p0_size), .p0_wr_data(p0_wr_data), .p0_rd_data(p0_rd_data),
    .p0_ack(p0_ack),
    .p1_rd_en(p1_rd_en), .p1_wr_en(p1_wr_en), .p1_addr(p1_addr),
    .p1_size(p1_size), .p1_wr_data(p1_wr_data), .p1_rd_data(p1_rd_data),
    .p1_ack(p1_ack),
    .ctrl_rd_enable(ctrl_rd_enable), .ctrl_wr_enable(ctrl_wr_enable),
    .ctrl_address(ctrl_address), .ctrl_rd_wr_size(ctrl_rd_wr_size),
    .ctrl_write_data(ctrl_write_data), .ctrl_busy(ctrl_busy),
    .ctrl_read_data(ctrl_read_data), .grant(grant), .arb_busy(arb_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_busy <= 1'b0;
      busy_cnt  <= 0;
      pre_cnt   <= 0;
    end else if (ctrl_busy) begin
      if (busy_cnt <= 1) ctrl_busy <= 1'b0;
      else               busy_cnt  <= busy_cnt - 1;
    end else if (ctrl_rd_enable || ctrl_wr_enable) begin
      if (pre_cnt >= holdoff) begin
        ctrl_busy <= 1'b1;
        busy_cnt  <= busy_len;
        pre_cnt   <= 0;
      end else begin
        pre_cnt <= pre_cnt + 1;
      end
    end else begin
      pre_cnt <= 0;
    end
  end

  // Free-running cycle counters; tests take before/after differences.
  always @(negedge clock) begin
    if (ctrl_rd_enable) rd_cyc++;
    if (ctrl_wr_enable) wr_cyc++;
    if (p0_ack)         a0_cyc++;
    if (p1_ack)         a1_cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_reqs();
    p0_rd_en = 0; p0_wr_en = 0; p1_rd_en = 0; p1_wr_en = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic wait_ack(output int who);
    who = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (p0_ack) begin who = 0; break; end
      if (p1_ack) begin who = 1; break; end
    end
    if (who < 0) check("ack_timeout", 0, 1);
  endtask

  task automatic wait_busy();
    int seen;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clock);
      if (ctrl_busy) seen = 1;
    end
    check("busy_timeout", 64'(seen), 1);
  endtask

  int who;
  int rd0, wr0, a00, a10;
  int exp_grant[3];

  initial begin
    p0_addr = '0; p0_size = '0; p0_wr_data = '0;
    p1_addr = '0; p1_size = '0; p1_wr_data = '0;
    ctrl_read_data = '0;
    reset = 1'b0;
    clear_reqs();
    #12;
    check("rst_rd_en",  64'(ctrl_rd_enable), 0);
    check("rst_wr_en",  64'(ctrl_wr_enable), 0);
    check("rst_addr",   64'(ctrl_address), 0);
    check("rst_size",   64'(ctrl_rd_wr_size), 0);
    check("rst_wdata",  ctrl_write_data, 0);
    check("rst_rd0",    p0_rd_data, 0);
    check("rst_rd1",    p1_rd_data, 0);
    check("rst_acks",   64'({p0_ack, p1_ack}), 0);
    check("rst_grant",  64'(grant), 0);
    check("rst_busy",   64'(arb_busy), 0);
    do_reset();

    // Single read on port 0
    ctrl_read_data = 64'h0000_0000_DEAD_BEEF;
    rd0 = rd_cyc; wr0 = wr_cyc; a00 = a0_cyc; a10 = a1_cyc;
    @(posedge clock); #1;
    p0_addr = 26'h000_0100; p0_size = 2'b10; p0_rd_en = 1;
    wait_ack(who);
    check("t1_who",   64'(who), 0);
    check("t1_busy",  64'(arb_busy), 1);
    check("t1_addr",  64'(ctrl_address), 64'h100);
    check("t1_size",  64'(ctrl_rd_wr_size), 2);
    @(posedge clock); #1 p0_rd_en = 0;
    repeat (3) @(negedge clock);
    check("t1_rdata", p0_rd_data, 64'h0000_0000_DEAD_BEEF);
    check("t1_ack0n", 64'(a0_cyc - a00), 1);
    check("t1_ack1n", 64'(a1_cyc - a10), 0);
    check("t1_rdenn", 64'(rd_cyc - rd0), 2);
    check("t1_wrenn", 64'(wr_cyc - wr0), 0);
    check("t1_idle",  64'(arb_busy), 0);

    // Single write on port 1
    ctrl_read_data = 64'hAAAA_5555_AAAA_5555;
    rd0 = rd_cyc; wr0 = wr_cyc; a00 = a0_cyc; a10 = a1_cyc;
    p1_addr = 26'h3FF_FFFF; p1_size = 2'b11; p1_wr_data = 64'h0123_4567_89AB_CDEF;
    p1_wr_en = 1;
    @(negedge clock); @(negedge clock);
    check("t2_wren",  64'(ctrl_wr_enable), 1);
    check("t2_rden",  64'(ctrl_rd_enable), 0);
    check("t2_addr",  64'(ctrl_address), 64'h3FF_FFFF);
    check("t2_wdata", ctrl_write_data, 64'h0123_4567_89AB_CDEF);
    check("t2_grant", 64'(grant), 1);
    wait_ack(who);
    check("t2_who",   64'(who), 1);
    @(posedge clock); #1 p1_wr_en = 0;
    repeat (3) @(negedge clock);
    check("t2_rd1",   p1_rd_data, 0);
    check("t2_rd0",   p0_rd_data, 64'h0000_0000_DEAD_BEEF);
    check("t2_ack1n", 64'(a1_cyc - a10), 1);
    check("t2_ack0n", 64'(a0_cyc - a00), 0);
    check("t2_wrenn", 64'(wr_cyc - wr0), 2);

    // rd_en and wr_en both high on port 0 must be a write
    rd0 = rd_cyc; wr0 = wr_cyc;
    @(posedge clock); #1;
    p0_addr = 26'h0000_0040; p0_wr_data = 64'h1111; p0_rd_en = 1; p0_wr_en = 1;
    wait_ack(who);
    check("t2b_who",  64'(who), 0);
    @(posedge clock); #1 clear_reqs();
    check("t2b_wrenn", 64'(wr_cyc - wr0), 2);
    check("t2b_rdenn", 64'(rd_cyc - rd0), 0);
    check("t2b_rd0",   p0_rd_data, 64'h0000_0000_DEAD_BEEF);

    // Simultaneous requests over three rounds
    do_reset();
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
    exp_grant = '{0, 1, 0};
`else
    exp_grant = '{0, 0, 0};
`endif
    @(posedge clock); #1;
    p0_addr = 26'h40; p1_addr = 26'h80; p0_rd_en = 1; p1_rd_en = 1;
    for (int r = 0; r < 3; r++) begin
      wait_ack(who);
      check($sformatf("t3_who%0d", r),   64'(who),   64'(exp_grant[r]));
      check($sformatf("t3_grant%0d", r), 64'(grant), 64'(exp_grant[r]));
      @(posedge clock); #1;
    end
    clear_reqs();
    repeat (2) @(negedge clock);

    // Port 1 changes its address while port 0 is being served
    do_reset();
    ctrl_read_data = 64'h77;
    @(posedge clock); #1;
    p0_addr = 26'h500; p1_addr = 26'h10; p0_rd_en = 1; p1_rd_en = 1;
    wait_busy();
    p1_addr = 26'h20;
    @(negedge clock);
    check("t4_grant0", 64'(grant), 0);
    check("t4_addr0",  64'(ctrl_address), 64'h500);
    wait_ack(who);
    check("t4_who0",   64'(who), 0);
    @(posedge clock); #1 p0_rd_en = 0;
    wait_ack(who);
    check("t4_who1",   64'(who), 1);
    check("t4_addr1",  64'(ctrl_address), 64'h20);
    check("t4_rd1",    p1_rd_data, 64'h77);
    @(posedge clock); #1 p1_rd_en = 0;

    // Controller delays busy by 10 cycles
    holdoff = 10;
    ctrl_read_data = 64'h55AA_55AA_0F0F_F0F0;
    rd0 = rd_cyc;
    @(posedge clock); #1;
    p0_addr = 26'h7; p0_size = 2'b01; p0_rd_en = 1;
    repeat (8) @(negedge clock);
    check("t5_en_held", 64'(ctrl_rd_enable), 1);
    check("t5_nobusy",  64'(ctrl_busy), 0);
    check("t5_arbbusy", 64'(arb_busy), 1);
    wait_ack(who);
    check("t5_who",     64'(who), 0);
    @(posedge clock); #1 p0_rd_en = 0;
    check("t5_rdenn",   64'(rd_cyc - rd0), 12);
    check("t5_rdata",   p0_rd_data, 64'h55AA_55AA_0F0F_F0F0);
    holdoff = 0;

    // Reset during WAIT of a read
    ctrl_read_data = 64'h9999;
    @(posedge clock); #1;
    p0_addr = 26'h123; p0_rd_en = 1;
    wait_busy();
    reset = 1'b0;
    #1;
    check("t6_rden",  64'(ctrl_rd_enable), 0);
    check("t6_wren",  64'(ctrl_wr_enable), 0);
    check("t6_acks",  64'({p0_ack, p1_ack}), 0);
    check("t6_busy",  64'(arb_busy), 0);
    check("t6_rd0",   p0_rd_data, 0);
    check("t6_rd1",   p1_rd_data, 0);
    check("t6_addr",  64'(ctrl_address), 0);
    p0_rd_en = 0;
    @(posedge clock); #1 reset = 1'b1;
    ctrl_read_data = 64'hCAFE_F00D;
    @(posedge clock); #1;
    p0_addr = 26'h200; p0_rd_en = 1;
    wait_ack(who);
    check("t6_who",   64'(who), 0);
    @(posedge clock); #1 p0_rd_en = 0;
    check("t6_rdata", p0_rd_data, 64'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-port arbiter that shares one sdram_controller between two independent requesters, for example instruction fetch on port 0 and data access on port 1.
- Each port gets a level request / single-cycle acknowledge handshake.
- The arbiter latches the winning request, drives the controller's rd_enable/wr_enable/busy handshake, and returns read data to the owning port.
- It sits between the core memory stage and sdram_controller, replacing direct register-based access.

Parameters:
- addr_size, 26, address width; matches the controller address bus.
- data_size, 64, data width; matches controller read_data/write_data.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- p0_rd_en  input  1  port 0 read request (level).
- p0_wr_en  input  1  port 0 write request (level).
- p0_addr  input  addr_size  port 0 address.
- p0_size  input  2  port 0 size: 00 byte, 01 half, 10 word, 11 double.
- p0_wr_data  input  data_size  port 0 write data.
- p0_rd_data  output  data_size  port 0 last read result.
- p0_ack  output  1  port 0 completion pulse.
- p1_rd_en, p1_wr_en, p1_addr, p1_size, p1_wr_data, p1_rd_data, p1_ack: same widths and meanings for port 1.
- ctrl_rd_enable  output  1  to controller rd_enable.
- ctrl_wr_enable  output  1  to controller wr_enable.
- ctrl_address  output  addr_size  to controller address.
- ctrl_rd_wr_size  output  2  to controller rd_wr_size.
- ctrl_write_data  output  data_size  to controller write_data.
- ctrl_busy  input  1  controller busy.
- ctrl_read_data  input  data_size  controller read_data.
- grant  output  1  owning port of the current or last transaction.
- arb_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0: ctrl_* enables, ctrl_address, ctrl_rd_wr_size, ctrl_write_data, p0/p1_rd_data, acks, grant, arb_busy. Last-winner register = 1.
- Request rules:
  - A port requests while rd_en|wr_en is high.
  - The requester holds enables and operands stable until its ack is sampled high, and drops its request on that same edge.
  - rd_en and wr_en both high counts as a write.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request is present, select a winner (fixed priority: port 0 beats port 1).
  - Latch the winner's addr, size, wr_data and op into the ctrl_* registers; set grant to the winner; go to ISSUE.
  - If no request is present, stay in IDLE.
- ISSUE:
  - ctrl_rd_enable or ctrl_wr_enable = latched op (exactly one high).
  - When ctrl_busy=1, drop both enables and go to WAIT. Otherwise stay in ISSUE, with no timeout.
- WAIT: when ctrl_busy=0, go to DONE. If the op was a read, capture ctrl_read_data into p<grant>_rd_data on this edge.
- DONE:
  - p<grant>_ack=1 (Moore output, exactly one cycle); next state is IDLE.
  - The new request set is evaluated in the following IDLE cycle.
- Latency: minimum request-to-ack = 4 cycles plus the controller's busy duration.
- ctrl_address, ctrl_rd_wr_size and ctrl_write_data change only on an IDLE grant and hold until the next grant.
- p*_rd_data holds until that port's next read completes; a write never alters it.
- Requests that arrive or change while arb_busy=1 are ignored until IDLE. The losing port waits with no ack.
- A port dropping its request before ack is a protocol violation. The transaction still completes and ack still pulses.
- Reset asserted mid-transaction returns outputs immediately to reset values. The controller must be reset by the same signal.

Optional Feature:
- Macro: SDRAM_ARBITER_ROUND_ROBIN_EN.
- When defined: on simultaneous requests in IDLE, the port that did not win the previous grant wins, tracked by the last-winner register. After reset, the last winner is 1, so port 0 wins the first tie. A single requesting port always wins.
- When undefined: fixed priority, port 0 always wins ties; the last-winner register is not instantiated.

Test Plan:
- Single read, port 0, addr=0x0000100, size=10; controller model busy for 5 cycles returning 0x00000000DEADBEEF -> p0_rd_data=0x00000000DEADBEEF. p0_ack high exactly 1 cycle. p1_ack stays 0. ctrl_rd_enable high only in ISSUE.
- Single write, port 1, addr=0x3FFFFFF, size=11, data=0x0123456789ABCDEF -> ctrl_wr_enable=1, ctrl_address=0x3FFFFFF, ctrl_write_data=0x0123456789ABCDEF. p1_ack pulses once. p1_rd_data is unchanged (0).
- Both ports request reads in the same cycle, with requests reissued after each ack for 3 rounds:
  - Without the macro -> grant sequence 0,0,0 and p1 starved.
  - With SDRAM_ARBITER_ROUND_ROBIN_EN -> grant sequence 0,1,0.
- Port 1 changes p1_addr from 0x10 to 0x20 while port 0 is in WAIT -> port 0 completes. Port 1 is then granted with ctrl_address=0x20.
- Controller holds ctrl_busy=0 for 10 cycles after issue -> FSM stays in ISSUE with the enable held, then completes normally once busy rises and falls.
- Drive reset=0 during WAIT of a read -> same cycle: ctrl enables 0, acks 0, arb_busy 0, rd_data 0. After release, a fresh port 0 request completes normally.
